lbm_lattice_bank: RTL

- Parametrised ping-pong storage for NUM_DIR lattice distribution channels. Replaces the per-direction hand-instantiated RAM pairs and the fixed init wiring.
- Holds two banks, "current" and "next", each NUM_DIR x DEPTH x DATA_WIDTH.
- Sits between the pipelined LBM solver and the host GPIO readout. Provides:
  - an init-fill engine,
  - solver read/write ports,
  - bank swap at step boundaries,
  - an arbitrated host read port.

---
 rtl/lbm_lattice_bank.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/lbm_lattice_bank.sv
// lbm_lattice_bank: ping-pong storage for NUM_DIR lattice distribution channels.
// Two banks ("current" = bank_sel, "next" = ~bank_sel), each built from NUM_DIR
// single-port synchronous RAMs. Provides an init-fill engine, solver read/write
// ports, bank swap at step boundaries and a host read port that yields to the solver.
// Optional macro LBM_BANK_OOR_EN: adds sticky oor_err, suppresses out-of-range
// writes and returns zero for out-of-range reads.
module lbm_lattice_bank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 2500,
    parameter int unsigned NUM_DIR    = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_start,
    input  logic [NUM_DIR*DATA_WIDTH-1:0] init_vals,
    output logic                          init_done,
    output logic                          busy,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [NUM_DIR*DATA_WIDTH-1:0] rd_data,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [NUM_DIR*DATA_WIDTH-1:0] wr_data,
    input  logic                          swap,
    output logic                          bank_sel,
    input  logic                          host_req,
    input  logic [ADDR_WIDTH-1:0]         host_addr,
    output logic                          host_ack,
    output logic                          host_valid,
    output logic [NUM_DIR*DATA_WIDTH-1:0] host_data
`ifdef LBM_BANK_OOR_EN
    ,
    output logic                          oor_err
`endif
);

    localparam int unsigned VW = NUM_DIR * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;
    logic                  init_done_q;
    logic                  bank_sel_q;

    logic                  rd_oor;
    logic                  wr_oor;
    logic                  host_oor;

    logic                  not_fill;
    logic                  rd_go;
    logic                  wr_go;
    logic                  host_go;

    // RAM port bundles, indexed by physical bank
    logic [ADDR_WIDTH-1:0] ram_addr  [2];
    logic                  ram_we    [2];
    logic                  ram_re    [2];
    logic [VW-1:0]         ram_wdata [2];
    logic [VW-1:0]         ram_rdata [2];

    // Read-side pipeline: pending flags select RAM output for one cycle, else hold
    logic                  rd_pend_q;
    logic                  rd_bank_q;
    logic                  rd_oor_q;
    logic [VW-1:0]         rd_hold_q;
    logic [VW-1:0]         rd_data_d;
    logic                  host_pend_q;
    logic                  host_bank_q;
    logic                  host_oor_q;
    logic [VW-1:0]         host_hold_q;
    logic [VW-1:0]         host_data_d;

`ifdef LBM_BANK_OOR_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
    logic oor_err_q;

    assign rd_oor   = ({1'b0, rd_addr}   >= DEPTH_X);
    assign wr_oor   = ({1'b0, wr_addr}   >= DEPTH_X);
    assign host_oor = ({1'b0, host_addr} >= DEPTH_X);
    assign oor_err  = oor_err_q;

    // Sticky out-of-range flag for any solver access or accepted host read
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_err_q <= 1'b0;
        end else if ((rd_go && rd_oor) || (not_fill && wr_en && wr_oor) ||
                     (host_go && host_oor)) begin
            oor_err_q <= 1'b1;
        end
    end
`else
    assign rd_oor   = 1'b0;
    assign wr_oor   = 1'b0;
    assign host_oor = 1'b0;
`endif

    assign not_fill   = (state_q != FILL);
    assign rd_go      = rd_en && not_fill;
    assign wr_go      = wr_en && not_fill && !wr_oor;
    // Solver has priority: host is served only in a non-fill cycle without rd_en
    assign host_go    = host_req && !rd_en && not_fill && !rst;

    assign host_ack   = host_go;
    assign host_valid = host_pend_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign bank_sel   = bank_sel_q;
    assign rd_data    = rd_data_d;
    assign host_data  = host_data_d;

    // Control FSM: fill sequencing, status flags and bank selection
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            bank_sel_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (swap) begin
                        bank_sel_q <= ~bank_sel_q;
                    end
                    if (init_start) begin
                        state_q     <= FILL;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        init_done_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Port mux per physical bank: fill > solver > host
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            ram_addr[b]  = '0;
            ram_we[b]    = 1'b0;
            ram_re[b]    = 1'b0;
            ram_wdata[b] = '0;
        end
        if (state_q == FILL) begin
            for (int unsigned b = 0; b < 2; b++) begin
                ram_addr[b]  = cnt_q;
                ram_we[b]    = 1'b1;
                ram_wdata[b] = init_vals;
            end
        end else begin
            if (rd_go) begin
                ram_re[bank_sel_q]   = 1'b1;
                ram_addr[bank_sel_q] = rd_addr;
            end else if (host_go) begin
                ram_re[bank_sel_q]   = 1'b1;
                ram_addr[bank_sel_q] = host_addr;
            end
            if (wr_go) begin
                ram_we[~bank_sel_q]    = 1'b1;
                ram_addr[~bank_sel_q]  = wr_addr;
                ram_wdata[~bank_sel_q] = wr_data;
            end
        end
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] q;

            // Single-port synchronous RAM for one channel of one bank
            always_ff @(posedge clk) begin
                if (ram_we[b]) begin
                    mem[ram_addr[b]] <= ram_wdata[b][d*DATA_WIDTH +: DATA_WIDTH];
                end
                if (ram_re[b]) begin
                    q <= mem[ram_addr[b]];
                end
            end

            assign ram_rdata[b][d*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    end

    // Output selection: fresh RAM data in the cycle after a read, otherwise held value.
    // The bank is latched at issue time so a same-cycle swap reads the pre-swap bank.
    always_comb begin
        rd_data_d   = rd_hold_q;
        host_data_d = host_hold_q;
        if (rd_pend_q) begin
            rd_data_d = rd_oor_q ? '0 : ram_rdata[rd_bank_q];
        end
        if (host_pend_q) begin
            host_data_d = host_oor_q ? '0 : ram_rdata[host_bank_q];
        end
    end

    // Read pipeline registers and output hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
            rd_hold_q   <= '0;
            host_pend_q <= 1'b0;
            host_bank_q <= 1'b0;
            host_oor_q  <= 1'b0;
            host_hold_q <= '0;
        end else begin
            rd_pend_q   <= rd_go;
            rd_bank_q   <= bank_sel_q;
            rd_oor_q    <= rd_oor;
            rd_hold_q   <= rd_data_d;
            host_pend_q <= host_go;
            host_bank_q <= bank_sel_q;
            host_oor_q  <= host_oor;
            host_hold_q <= host_data_d;
        end
    end

endmodule
